// File: rtl/pin_entry_collector.sv
// Collects a 4-digit hex keypad code and submits it to the lock on enter; edge-detected keys.
// All outputs registered, one cycle after the triggering edge; no backpressure, dropped events are not deferred.
module pin_entry_collector #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        keyPress,
   input  logic [3:0]  keyCode,
   input  logic        enterKey,
   input  logic        clearKey,
   input  logic        inhibit,
   output logic [15:0] pinCode,
   output logic        trig,
   output logic [2:0]  digitCount,
   output logic        entryErr,
   output logic        timeoutPulse
);

   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]  CNT_EMPTY = 3'd0;
   localparam logic [2:0]  CNT_FULL  = 3'd4;

   logic        r_key_q;
   logic        r_ent_q;
   logic        r_clr_q;
   logic [15:0] r_shift;
   logic [2:0]  r_count;
   logic [15:0] r_timer;
   logic [15:0] r_pin;
   logic        r_trig;
   logic        r_err;
   logic        r_to;

   logic        w_key_ev;
   logic        w_ent_ev;
   logic        w_clr_ev;
   logic        w_full;
   logic [15:0] w_nxt_shift;
   logic [2:0]  w_nxt_count;
   logic [15:0] w_nxt_timer;
   logic [15:0] w_nxt_pin;
   logic        w_nxt_trig;
   logic        w_nxt_err;
   logic        w_nxt_to;

   assign w_key_ev = keyPress & ~r_key_q;
   assign w_ent_ev = enterKey & ~r_ent_q;
   assign w_clr_ev = clearKey & ~r_clr_q;
   assign w_full   = (r_count == CNT_FULL);

   // Priority chain: inhibit, clear, enter, digit, then the idle timer.
   always_comb begin
      w_nxt_shift = r_shift;
      w_nxt_count = r_count;
      w_nxt_timer = r_timer;
      w_nxt_pin   = r_pin;
      w_nxt_trig  = 1'b0;
      w_nxt_err   = 1'b0;
      w_nxt_to    = 1'b0;
      if (inhibit) begin
         w_nxt_shift = 16'h0000;
         w_nxt_count = CNT_EMPTY;
         w_nxt_timer = 16'h0000;
         w_nxt_err   = w_ent_ev;
      end else if (w_clr_ev) begin
         w_nxt_shift = 16'h0000;
         w_nxt_count = CNT_EMPTY;
         w_nxt_timer = 16'h0000;
      end else if (w_ent_ev) begin
         if (w_full) begin
            w_nxt_pin  = r_shift;
            w_nxt_trig = 1'b1;
         end else begin
            w_nxt_err  = 1'b1;
         end
         w_nxt_shift = 16'h0000;
         w_nxt_count = CNT_EMPTY;
         w_nxt_timer = 16'h0000;
      end else if (w_key_ev && !w_full) begin
         w_nxt_shift = {r_shift[11:0], keyCode};
         w_nxt_count = r_count + 3'd1;
         w_nxt_timer = 16'h0000;
      end else if (r_count == CNT_EMPTY) begin
         w_nxt_timer = 16'h0000;
      end else if (r_timer == TO_LAST) begin
         // A digit pressed while full is not accepted, so it does not save the entry.
         w_nxt_shift = 16'h0000;
         w_nxt_count = CNT_EMPTY;
         w_nxt_timer = 16'h0000;
         w_nxt_to    = 1'b1;
      end else begin
         w_nxt_timer = r_timer + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key_q <= 1'b0;
         r_ent_q <= 1'b0;
         r_clr_q <= 1'b0;
         r_shift <= 16'h0000;
         r_count <= CNT_EMPTY;
         r_timer <= 16'h0000;
         r_pin   <= 16'h0000;
         r_trig  <= 1'b0;
         r_err   <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_key_q <= keyPress;
         r_ent_q <= enterKey;
         r_clr_q <= clearKey;
         r_shift <= w_nxt_shift;
         r_count <= w_nxt_count;
         r_timer <= w_nxt_timer;
         r_pin   <= w_nxt_pin;
         r_trig  <= w_nxt_trig;
         r_err   <= w_nxt_err;
         r_to    <= w_nxt_to;
      end
   end

   assign pinCode      = r_pin;
   assign trig         = r_trig;
   assign digitCount   = r_count;
   assign entryErr     = r_err;
   assign timeoutPulse = r_to;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed vector bench for pin_entry_collector with an 8-cycle idle timeout.
module tb_pin_entry_collector;

   logic        clk;
   logic        rst;
   logic        keyPress;
   logic [3:0]  keyCode;
   logic        enterKey;
   logic        clearKey;
   logic        inhibit;
   logic [15:0] pinCode;
   logic        trig;
   logic [2:0]  digitCount;
   logic        entryErr;
   logic        timeoutPulse;

   typedef struct {
      logic        kp;
      logic [3:0]  kc;
      logic        en;
      logic        cl;
      logic        inh;
      logic [15:0] pin;
      logic        trig;
      logic [2:0]  cnt;
      logic        err;
      logic        to;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cur    = 0;

   pin_entry_collector #(.TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .keyPress     (keyPress),
      .keyCode      (keyCode),
      .enterKey     (enterKey),
      .clearKey     (clearKey),
      .inhibit      (inhibit),
      .pinCode      (pinCode),
      .trig         (trig),
      .digitCount   (digitCount),
      .entryErr     (entryErr),
      .timeoutPulse (timeoutPulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
      end
   endtask

   task automatic chk_all(input vec_t v);
      chk("pinCode", pinCode, v.pin);
      chk("trig", {15'd0, trig}, {15'd0, v.trig});
      chk("digitCount", {13'd0, digitCount}, {13'd0, v.cnt});
      chk("entryErr", {15'd0, entryErr}, {15'd0, v.err});
      chk("timeoutPulse", {15'd0, timeoutPulse}, {15'd0, v.to});
   endtask

   function automatic vec_t mk(input logic kp, input logic [3:0] kc, input logic en, input logic cl,
                               input logic inh, input logic [15:0] pin, input logic tr,
                               input logic [2:0] cnt, input logic err, input logic to);
      vec_t v;
      v.kp = kp; v.kc = kc; v.en = en; v.cl = cl; v.inh = inh;
      v.pin = pin; v.trig = tr; v.cnt = cnt; v.err = err; v.to = to;
      return v;
   endfunction

   task automatic add(input logic kp, input logic [3:0] kc, input logic en, input logic cl,
                      input logic inh, input logic [15:0] pin, input logic tr,
                      input logic [2:0] cnt, input logic err, input logic to);
      vecs.push_back(mk(kp, kc, en, cl, inh, pin, tr, cnt, err, to));
   endtask

   // One key held for three cycles then released for one.
   task automatic key(input logic [3:0] c, input logic [2:0] cnt, input logic [15:0] pin);
      for (int i = 0; i < 3; i++) add(1'b1, c, 1'b0, 1'b0, 1'b0, pin, 1'b0, cnt, 1'b0, 1'b0);
      add(1'b0, c, 1'b0, 1'b0, 1'b0, pin, 1'b0, cnt, 1'b0, 1'b0);
   endtask

   task automatic apply(input vec_t v);
      keyPress = v.kp;
      keyCode  = v.kc;
      enterKey = v.en;
      clearKey = v.cl;
      inhibit  = v.inh;
      @(posedge clk);
      #1;
      chk_all(v);
      cur++;
   endtask

   initial begin
      // Full code submit, enter held two cycles.
      key(4'hA, 3'd1, 16'h0000); key(4'hB, 3'd2, 16'h0000);
      key(4'hC, 3'd3, 16'h0000); key(4'hD, 3'd4, 16'h0000);
      add(0, 0, 1, 0, 0, 16'hABCD, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 16'hABCD, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 16'hABCD, 0, 0, 0, 0);
      // Short submit.
      key(4'hC, 3'd1, 16'hABCD); key(4'hA, 3'd2, 16'hABCD);
      add(0, 0, 1, 0, 0, 16'hABCD, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 16'hABCD, 0, 0, 0, 0);
      // Fifth digit ignored.
      key(4'h1, 3'd1, 16'hABCD); key(4'h2, 3'd2, 16'hABCD);
      key(4'h3, 3'd3, 16'hABCD); key(4'h4, 3'd4, 16'hABCD);
      add(1, 5, 0, 0, 0, 16'hABCD, 0, 4, 0, 0);
      add(0, 5, 0, 0, 0, 16'hABCD, 0, 4, 0, 0);
      add(0, 0, 1, 0, 0, 16'h1234, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
      // Timeout eight cycles after the accepted edge.
      for (int i = 0; i < 3; i++) add(1, 4'hF, 0, 0, 0, 16'h1234, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 4'hF, 0, 0, 0, 16'h1234, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
      // Enter on the timeout cycle wins over the timeout.
      add(1, 4'h7, 0, 0, 0, 16'h1234, 0, 1, 0, 0);
      for (int i = 0; i < 7; i++) add(0, 4'h7, 0, 0, 0, 16'h1234, 0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 16'h1234, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
      // Clear beats enter.
      key(4'hD, 3'd1, 16'h1234); key(4'hA, 3'd2, 16'h1234);
      add(0, 0, 1, 1, 0, 16'h1234, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
      // Enter beats digit.
      key(4'h1, 3'd1, 16'h1234); key(4'h2, 3'd2, 16'h1234); key(4'h3, 3'd3, 16'h1234);
      add(1, 4'h4, 1, 0, 0, 16'h1234, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
      // Plain clear of a partial entry.
      key(4'h5, 3'd1, 16'h1234); key(4'h6, 3'd2, 16'h1234);
      add(0, 0, 0, 1, 0, 16'h1234, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
      // Inhibit flushes a partial entry and blocks keys; enter still errors.
      key(4'h5, 3'd1, 16'h1234); key(4'h6, 3'd2, 16'h1234);
      add(0, 0, 0, 0, 1, 16'h1234, 0, 0, 0, 0);
      add(1, 4'h9, 0, 0, 1, 16'h1234, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 16'h1234, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 16'h1234, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 16'h1234, 0, 0, 0, 0);
      add(0, 0, 1, 0, 1, 16'h1234, 0, 0, 1, 0);
      add(0, 0, 0, 0, 1, 16'h1234, 0, 0, 0, 0);
      add(1, 4'h8, 0, 0, 0, 16'h1234, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 16'h1234, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
      // Full buffer plus enter under inhibit: error, no submit.
      key(4'h9, 3'd1, 16'h1234); key(4'h8, 3'd2, 16'h1234);
      key(4'h7, 3'd3, 16'h1234); key(4'h6, 3'd4, 16'h1234);
      add(0, 0, 1, 0, 1, 16'h1234, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 0);

      rst = 1'b0; keyPress = 1'b0; keyCode = 4'h0;
      enterKey = 1'b0; clearKey = 1'b0; inhibit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
      rst = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // Reset in the middle of a full entry, with a key held through reset.
      apply(mk(1, 4'hB, 0, 0, 0, 16'h1234, 0, 1, 0, 0));
      apply(mk(0, 4'hB, 0, 0, 0, 16'h1234, 0, 1, 0, 0));
      apply(mk(1, 4'hA, 0, 0, 0, 16'h1234, 0, 2, 0, 0));
      apply(mk(0, 4'hA, 0, 0, 0, 16'h1234, 0, 2, 0, 0));
      apply(mk(1, 4'hB, 0, 0, 0, 16'h1234, 0, 3, 0, 0));
      apply(mk(0, 4'hB, 0, 0, 0, 16'h1234, 0, 3, 0, 0));
      apply(mk(1, 4'hA, 0, 0, 0, 16'h1234, 0, 4, 0, 0));
      #3;
      rst = 1'b0;
      #1;
      chk_all(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
      keyPress = 1'b1; keyCode = 4'h3;
      @(posedge clk);
      #1;
      chk_all(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
      rst = 1'b1;
      apply(mk(1, 4'h3, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
      apply(mk(1, 4'h3, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
      apply(mk(0, 4'h3, 0, 0, 0, 16'h0000, 0, 1, 0, 0));
      apply(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0));
      apply(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
